mac_dot_seq: RTL and testbench

- Upstream sequencer for the single MAC_Element datapath. It turns the element into a full dot-product engine.
- Holds an operand bank of x/w pairs, loaded through a write port.
- On a command, it issues one MAC operation per vector element and chains the accumulator back through acc_in. Each issue waits for the element's done pulse.
- It returns the final 2*DW sum on a valid/ready result port.
- Sits between the NPU controller/operand loader and MAC_Element.

---
 rtl/npu_pkg.sv | 18 +
 rtl/mac_operand_bank.sv | 44 ++++
 rtl/mac_dot_seq.sv | 170 +++++++++++++++++
 tb/tb_mac_dot_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// npu_pkg: shared definitions for the NPU MAC datapath and its sequencer.
//   - Default operand width, operand-bank depth and MAC watchdog timeout,
//     common to MAC_Element, mac_dot_seq and the upstream operand loader.
//   - seq_state_e: dot-product sequencer state encoding.
package npu_pkg;

    localparam int NPU_DW      = 16;
    localparam int NPU_LEN_MAX = 16;
    localparam int NPU_TIMEOUT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mac_operand_bank.sv
// mac_operand_bank: LEN_MAX x {x, w} operand register file.
//   clk      in   clock
//   i_we     in   write enable (already qualified by the caller)
//   i_waddr  in   write address
//   i_wx     in   activation operand to store
//   i_ww     in   weight operand to store
//   i_raddr  in   read address
//   o_rx     out  activation at i_raddr (combinational read)
//   o_rw     out  weight at i_raddr (combinational read)
// Contents are deliberately not reset.
module mac_operand_bank #(
    parameter int DW      = 16,
    parameter int LEN_MAX = 16,
    parameter int AW      = 4
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic signed [DW-1:0] i_wx,
    input  logic signed [DW-1:0] i_ww,
    input  logic [AW-1:0]        i_raddr,
    output logic signed [DW-1:0] o_rx,
    output logic signed [DW-1:0] o_rw
);

    logic [2*DW-1:0] w_entries [LEN_MAX];

    for (genvar gi = 0; gi < LEN_MAX; gi++) begin : g_entry
        logic [2*DW-1:0] r_data;

        always_ff @(posedge clk) begin
            if (i_we && (i_waddr == AW'(gi))) begin
                r_data <= {i_wx, i_ww};
            end
        end

        assign w_entries[gi] = r_data;
    end

    // Asynchronous read so a write landing on the command-accept edge is
    // visible to the very first ISSUE cycle.
    assign {o_rx, o_rw} = w_entries[i_raddr];

endmodule

// File: rtl/mac_dot_seq.sv
// mac_dot_seq: dot-product sequencer in front of a single MAC_Element.
// Loads x/w pairs into an operand bank, then on a command issues one MAC
// operation per element, chaining the accumulator through mac_acc_in, and
// returns bias + sum(x*w) on a valid/ready result port.
//   clk, rst                 clock, synchronous active-high reset
//   ld_en/ld_addr/ld_x/ld_w  operand bank write port (honoured in IDLE only)
//   cmd_valid/cmd_ready      start handshake; cmd_len (0..LEN_MAX), cmd_bias
//   mac_start/mac_x/mac_w/mac_acc_in   issue side to MAC_Element
//   mac_acc_out/mac_done               return side from MAC_Element
//   res_valid/res_ready/res_data/res_err  result handshake; res_err flags a
//                            MAC timeout (res_data then holds the partial sum)
module mac_dot_seq
    import npu_pkg::*;
#(
    parameter int  DW      = NPU_DW,
    parameter int  LEN_MAX = NPU_LEN_MAX,
    parameter int  TIMEOUT = NPU_TIMEOUT,
    localparam int AW      = $clog2(LEN_MAX)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_en,
    input  logic [AW-1:0]          ld_addr,
    input  logic signed [DW-1:0]   ld_x,
    input  logic signed [DW-1:0]   ld_w,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [AW:0]            cmd_len,
    input  logic signed [2*DW-1:0] cmd_bias,
    output logic                   mac_start,
    output logic signed [DW-1:0]   mac_x,
    output logic signed [DW-1:0]   mac_w,
    output logic signed [2*DW-1:0] mac_acc_in,
    input  logic signed [2*DW-1:0] mac_acc_out,
    input  logic                   mac_done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic signed [2*DW-1:0] res_data,
    output logic                   res_err
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    seq_state_e              r_state;
    seq_state_e              w_state_next;
    logic [AW-1:0]           r_idx;
    logic [AW:0]             r_len;
    logic signed [2*DW-1:0]  r_acc;
    logic [WDW-1:0]          r_wdog;
    logic                    r_err;

    logic                    w_ld_we;
    logic [AW:0]             w_len_clamped;
    logic                    w_last;
    logic                    w_wdog_expired;
    logic                    w_active;
    logic signed [DW-1:0]    w_rx;
    logic signed [DW-1:0]    w_rw;

    // Widen the address before the range check so it stays meaningful when
    // LEN_MAX is not a power of two.
    assign w_ld_we = ld_en && (r_state == IDLE)
                     && ({1'b0, ld_addr} < (AW+1)'(LEN_MAX));

    assign w_len_clamped  = (cmd_len > (AW+1)'(LEN_MAX)) ? (AW+1)'(LEN_MAX) : cmd_len;
    assign w_last         = ({1'b0, r_idx} == (r_len - 1'b1));
    assign w_wdog_expired = (r_wdog == WDW'(TIMEOUT - 1));

    mac_operand_bank #(
        .DW      (DW),
        .LEN_MAX (LEN_MAX),
        .AW      (AW)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_ld_we),
        .i_waddr (ld_addr),
        .i_wx    (ld_x),
        .i_ww    (ld_w),
        .i_raddr (r_idx),
        .o_rx    (w_rx),
        .o_rw    (w_rw)
    );

    // Operands stay stable across ISSUE and WAIT because idx/acc only move on
    // the mac_done edge; outside a MAC operation the issue bus is parked at 0.
    assign w_active   = (r_state == ISSUE) || (r_state == WAIT);
    assign mac_x      = w_active ? w_rx  : '0;
    assign mac_w      = w_active ? w_rw  : '0;
    assign mac_acc_in = w_active ? r_acc : '0;
    assign res_data   = (r_state == DONE) ? r_acc : '0;
    assign res_err    = r_err;

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        mac_start    = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = (w_len_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                mac_start    = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (mac_done) begin
                    w_state_next = w_last ? DONE : ISSUE;
                end else if (w_wdog_expired) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_acc   <= '0;
            r_wdog  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_len <= w_len_clamped;
                        r_acc <= cmd_bias;
                        r_idx <= '0;
                        r_err <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_wdog <= '0;
                end
                WAIT: begin
                    if (mac_done) begin
                        r_acc <= mac_acc_out;
                        if (!w_last) begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end else if (w_wdog_expired) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + WDW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq with a behavioural MAC_Element model.
module tb_mac_dot_seq;

    localparam int DW = 16;
    localparam int AW = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   ld_en = 1'b0;
    logic [AW-1:0]          ld_addr = '0;
    logic signed [DW-1:0]   ld_x = '0;
    logic signed [DW-1:0]   ld_w = '0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [AW:0]            cmd_len = '0;
    logic signed [2*DW-1:0] cmd_bias = '0;
    logic                   mac_start;
    logic signed [DW-1:0]   mac_x;
    logic signed [DW-1:0]   mac_w;
    logic signed [2*DW-1:0] mac_acc_in;
    logic signed [2*DW-1:0] mac_acc_out = '0;
    logic                   mac_done = 1'b0;
    logic                   res_valid;
    logic                   res_ready = 1'b1;
    logic signed [2*DW-1:0] res_data;
    logic                   res_err;

    mac_dot_seq u_dut (
        .clk         (clk),
        .rst         (rst),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_x        (ld_x),
        .ld_w        (ld_w),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .cmd_bias    (cmd_bias),
        .mac_start   (mac_start),
        .mac_x       (mac_x),
        .mac_w       (mac_w),
        .mac_acc_in  (mac_acc_in),
        .mac_acc_out (mac_acc_out),
        .mac_done    (mac_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err)
    );

    always #5 clk = ~clk;

    // MAC_Element model: done and the product-sum appear the cycle after start.
    logic mac_en = 1'b1;
    always @(posedge clk) begin
        mac_done <= mac_start && mac_en;
        if (mac_start) mac_acc_out <= mac_acc_in + mac_x * mac_w;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        longint data;
        longint err;
        int     lat;     // cycles from accept cycle to res_valid, -1 = skip
        int     nstart;  // expected mac_start samples for this command
        int     base;    // start_cnt when the command was accepted
        int     acc_cyc; // cyc right after the accept edge
    } exp_t;

    exp_t sb[$];
    int   start_cnt  = 0;
    logic prev_valid = 1'b0;

    // Monitor: latency on res_valid rise, data/err/pulse count on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (mac_start) start_cnt++;
        if (!rst && res_valid && !prev_valid) begin
            if (sb.size() == 0) check("unexpected_result", 1, 0);
            else if (sb[0].lat >= 0) check("latency", cyc - sb[0].acc_cyc + 1, sb[0].lat);
        end
        if (!rst && res_valid && res_ready && sb.size() > 0) begin
            e = sb.pop_front();
            $display("result data=%0d err=%0d starts=%0d", res_data, res_err, start_cnt - e.base);
            check("res_data", res_data, e.data);
            check("res_err", res_err, e.err);
            check("mac_start_pulses", start_cnt - e.base, e.nstart);
        end
        prev_valid = res_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input int x, input int w);
        ld_en = 1'b1; ld_addr = AW'(addr); ld_x = DW'(x); ld_w = DW'(w);
        tick();
        ld_en = 1'b0;
    endtask

    task automatic load_1234();
        load(0, 1, 5); load(1, 2, 6); load(2, 3, 7); load(3, 4, 8);
    endtask

    // Accepts one command; optionally pushes its expected result.
    task automatic issue_cmd(input int len, input int bias, input bit push,
                             input longint exp_data, input longint exp_err,
                             input int exp_lat, input int exp_nstart);
        exp_t e;
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_len = (AW+1)'(len); cmd_bias = 32'(bias);
        tick();
        cmd_valid = 1'b0;
        if (push) begin
            e.data = exp_data; e.err = exp_err; e.lat = exp_lat;
            e.nstart = exp_nstart; e.base = start_cnt; e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) check("wait_idle_timeout", 0, 1);
    endtask

    task automatic run(input int len, input int bias, input longint exp_data,
                       input longint exp_err, input int exp_lat, input int exp_nstart);
        issue_cmd(len, bias, 1'b1, exp_data, exp_err, exp_lat, exp_nstart);
        wait_idle();
    endtask

    initial begin
        repeat (3) tick();
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_res_valid", res_valid, 0);
        check("reset_mac_start", mac_start, 0);
        check("reset_res_data", res_data, 0);
        check("reset_res_err", res_err, 0);
        check("reset_mac_acc_in", mac_acc_in, 0);
        rst = 1'b0;
        tick();

        // Basic dot product: 10 + 5 + 12 + 21 + 32 = 80, 9-cycle latency.
        load_1234();
        run(4, 10, 80, 0, 9, 4);

        // Write to addr 0 in the same cycle as the command is accepted.
        load(1, 32767, 32767);
        ld_en = 1'b1; ld_addr = 0; ld_x = -3; ld_w = 4;
        issue_cmd(2, 0, 1'b1, 1073676277, 0, 5, 2);
        ld_en = 1'b0;
        wait_idle();

        // Zero-length command returns the bias on the next cycle.
        run(0, -7, -7, 0, 1, 0);

        // MAC never completes: partial sum (bias) with error after TIMEOUT WAITs.
        mac_en = 1'b0;
        run(3, 2, 2, 1, 10, 1);
        mac_en = 1'b1;
        load_1234();
        run(4, 10, 80, 0, 9, 4);

        // Back-pressure: result held, no command accepted, bank writes ignored.
        res_ready = 1'b0;
        issue_cmd(4, 10, 1'b1, 80, 0, 9, 4);
        for (int i = 0; i < 50 && !res_valid; i++) tick();
        check("bp_res_valid_seen", res_valid, 1);
        ld_en = 1'b1; ld_addr = 0; ld_x = 100; ld_w = 100;
        for (int i = 0; i < 20; i++) begin
            check("bp_res_data_stable", res_data, 80);
            check("bp_cmd_ready_low", cmd_ready, 0);
            check("bp_res_valid_held", res_valid, 1);
            tick();
        end
        ld_en = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        run(4, 10, 80, 0, 9, 4);

        // Reset in the second WAIT of a len=4 run aborts with no result.
        issue_cmd(4, 10, 1'b0, 0, 0, -1, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_res_valid", res_valid, 0);
        check("abort_mac_start", mac_start, 0);
        check("abort_res_err", res_err, 0);
        tick();
        run(4, 10, 80, 0, 9, 4);

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
